// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one multiplier among NREQ requesters; issue one cycle after grant,
// result LAT+1 cycles after issue, one transfer per cycle; no result back-pressure, owners always accept.
module mult_share_sched #(
    parameter int nBits = 32,
    parameter int NREQ  = 4,
    parameter int LAT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*nBits-1:0] req_a,
    input  logic [NREQ*nBits-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [nBits-1:0]      mul_a,
    output logic [nBits-1:0]      mul_b,
    output logic                  mul_en,
    input  logic [nBits-1:0]      mul_p,
    output logic [nBits-1:0]      res,
    output logic [NREQ-1:0]       res_valid,
    output logic                  busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic [NREQ-1:0] grant;
    logic            xfer;
    logic            busy_c;
    int              idx;
    logic [NREQ-1:0] tag [0:LAT];

    // Walk the search order backwards so the last hit is the first requester at/after ptr.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = 0;
        if (!rst) begin
            for (int off = NREQ - 1; off >= 0; off--) begin
                idx = (int'(ptr) + off) % NREQ;
                if (req_valid[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    gidx       = PW'(idx);
                end
            end
        end
    end

    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        busy_c = 1'b0;
        for (int j = 0; j <= LAT; j++) begin
            busy_c = busy_c | (|tag[j]);
        end
    end

    assign busy = busy_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_en    <= 1'b0;
            res       <= '0;
            res_valid <= '0;
            for (int j = 0; j <= LAT; j++) begin
                tag[j] <= '0;
            end
        end else begin
            mul_en <= xfer;
            if (xfer) begin
                mul_a <= req_a[gidx*nBits +: nBits];
                mul_b <= req_b[gidx*nBits +: nBits];
                ptr   <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end
            // Owner tag travels with the product; the last stage lines up with mul_p.
            tag[0] <= grant;
            for (int j = 1; j <= LAT; j++) begin
                tag[j] <= tag[j-1];
            end
            res_valid <= tag[LAT];
            if (|tag[LAT]) begin
                res <= mul_p;
            end
        end
    end
endmodule
